// File: rtl/bram_port_arb_pkg.sv
// Shared types and default widths for the two-requester BRAM port arbiter.
package bram_port_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 8;
  localparam int WE_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bram_port_arb_rr.sv
// Two-way round-robin pick: one-hot grant choice from two requests and a priority pointer.
module bram_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] pick_o
);

  // ptr_i = 0 favours requester 0, ptr_i = 1 favours requester 1
  always_comb begin
    pick_o = 2'b00;
    if (req_i == 2'b11) begin
      pick_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      pick_o = req_i;
    end
  end

endmodule

// File: rtl/bram_port_arb.sv
// Burst arbiter sharing one BRAM port between the cnn core (m0) and the host loader (m1).
module bram_port_arb
  import bram_port_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [WE_W-1:0]   m0_we,
  input  logic [DATA_W-1:0] m0_din,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [WE_W-1:0]   m1_we,
  input  logic [DATA_W-1:0] m1_din,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [WE_W-1:0]   BRAM_WE,
  output logic              BRAM_EN,
  output logic [DATA_W-1:0] BRAM_DIN,
  input  logic [DATA_W-1:0] BRAM_DOUT
);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rd_vld_q, rd_tag_q;
  logic             done0_q, done1_q;

  logic             own0, own1, beat0, beat1, beat, last;
  logic [1:0]       pick;
  logic             other_req;
  arb_state_e       other_st;
  logic [LEN_W-1:0] other_len, own_len;

  bram_rr_pick2 u_pick (
    .req_i  ({m1_req, m0_req}),
    .ptr_i  (ptr_q),
    .pick_o (pick)
  );

  assign own0  = (state_q == ST_OWN0);
  assign own1  = (state_q == ST_OWN1);
  assign beat0 = own0 & m0_req;
  assign beat1 = own1 & m1_req;
  assign beat  = beat0 | beat1;
  assign last  = beat && (cnt_q == len_q);

  assign other_req = own0 ? m1_req : m0_req;
  assign other_st  = own0 ? ST_OWN1 : ST_OWN0;
  assign other_len = own0 ? m1_len : m0_len;
  assign own_len   = own0 ? m0_len : m1_len;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (pick[0]) begin
          state_d = ST_OWN0;
          len_d   = m0_len;
          cnt_d   = '0;
        end else if (pick[1]) begin
          state_d = ST_OWN1;
          len_d   = m1_len;
          cnt_d   = '0;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (last) begin
          ptr_d = own0;
          cnt_d = '0;
          if (other_req) begin
            state_d = other_st;
            len_d   = other_len;
          end else begin
            len_d   = own_len;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == '0) begin
          // A burst that has issued no beat yet is not held: an owner that
          // lets go right after a handoff would otherwise lock the port.
          if (other_req) begin
            state_d = other_st;
            len_d   = other_len;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m0_gnt    = beat0;
    m1_gnt    = beat1;
    BRAM_EN   = beat;
    BRAM_ADDR = '0;
    BRAM_WE   = '0;
    BRAM_DIN  = '0;
    if (beat0) begin
      BRAM_ADDR = m0_addr;
      BRAM_WE   = m0_we;
      BRAM_DIN  = m0_din;
    end else if (beat1) begin
      BRAM_ADDR = m1_addr;
      BRAM_WE   = m1_we;
      BRAM_DIN  = m1_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_tag_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rd_vld_q <= beat && (BRAM_WE == '0);
      rd_tag_q <= beat1;
      done0_q  <= last & own0;
      done1_q  <= last & own1;
    end
  end

  // Read data is broadcast; the registered tag steers rvalid to the issuer.
  assign m0_rvalid = rd_vld_q & ~rd_tag_q;
  assign m1_rvalid = rd_vld_q &  rd_tag_q;
  assign m0_rdata  = BRAM_DOUT;
  assign m1_rdata  = BRAM_DOUT;
  assign m0_done   = done0_q;
  assign m1_done   = done1_q;

endmodule

// File: tb/tb_bram_port_arb.sv
// Scoreboard bench for bram_port_arb: directed bursts with hand-computed beat/rvalid/done cycles.
module tb_bram_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  logic          m_req  [2];
  logic [LW-1:0] m_len  [2];
  logic [AW-1:0] m_addr [2];
  logic [3:0]    m_we   [2];
  logic [DW-1:0] m_din  [2];

  logic          m0_gnt, m0_rvalid, m0_done, m1_gnt, m1_rvalid, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] BRAM_ADDR;
  logic [3:0]    BRAM_WE;
  logic          BRAM_EN;
  logic [DW-1:0] BRAM_DIN;
  logic [DW-1:0] BRAM_DOUT;

  bram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m_req[0]), .m0_len(m_len[0]), .m0_addr(m_addr[0]), .m0_we(m_we[0]), .m0_din(m_din[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_req(m_req[1]), .m1_len(m_len[1]), .m1_addr(m_addr[1]), .m1_we(m_we[1]), .m1_din(m_din[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_done(m1_done),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WE(BRAM_WE), .BRAM_EN(BRAM_EN), .BRAM_DIN(BRAM_DIN),
    .BRAM_DOUT(BRAM_DOUT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: byte writes, read-first, one-cycle read latency
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (BRAM_EN) begin
      for (int b = 0; b < 4; b++)
        if (BRAM_WE[b]) mem[BRAM_ADDR[5:0]][8*b +: 8] <= BRAM_DIN[8*b +: 8];
      BRAM_DOUT <= mem[BRAM_ADDR[5:0]];
    end
  end

  typedef struct {int cyc; int m; logic [AW-1:0] addr; logic [3:0] we; logic [DW-1:0] din;} beat_t;
  typedef struct {int cyc; int m; logic [DW-1:0] data;} ev_t;
  beat_t beat_q[$];
  ev_t   rv_q[$];
  ev_t   done_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  task automatic pb(input int c, input int m, input logic [AW-1:0] a, input logic [3:0] we, input logic [DW-1:0] d);
    beat_t b;
    b.cyc = c; b.m = m; b.addr = a; b.we = we; b.din = d;
    beat_q.push_back(b);
  endtask

  task automatic prv(input int c, input int m, input logic [DW-1:0] d);
    ev_t e;
    e.cyc = c; e.m = m; e.data = d;
    rv_q.push_back(e);
  endtask

  task automatic pdone(input int c, input int m);
    ev_t e;
    e.cyc = c; e.m = m; e.data = '0;
    done_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reactive requester: holds req, advances a beat each time gnt is seen
  task automatic master(input int m, input int nb, input logic [AW-1:0] a0, input logic [3:0] we,
                        input logic [DW-1:0] d0, input int stall_at, input int stall_n);
    int   i = 0;
    int   guard = 0;
    logic g;
    m_req[m]  = 1'b1;
    m_len[m]  = LW'(nb - 1);
    m_addr[m] = a0;
    m_we[m]   = we;
    m_din[m]  = (we != 0) ? d0 : '0;
    while (i < nb) begin
      @(negedge clk);
      g = (m == 0) ? m0_gnt : m1_gnt;
      step();
      if (g) begin
        i++;
        m_len[m]  = 8'hEE;
        m_addr[m] = a0 + i;
        if (we != 0) m_din[m] = d0 + i;
        if (i == stall_at && stall_n > 0) begin
          m_req[m] = 1'b0;
          repeat (stall_n) step();
          m_req[m] = 1'b1;
        end
      end
      guard++;
      if (guard > 60) begin
        fail("drv_timeout");
        break;
      end
    end
    m_req[m] = 1'b0;
    m_we[m]  = '0;
    m_din[m] = '0;
    m_len[m] = '0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat, rvalid or done
  initial begin
    beat_t b;
    ev_t   e;
    forever begin
      @(negedge clk);
      if (BRAM_EN) begin
        if (beat_q.size() == 0) fail("beat_extra");
        else begin
          b = beat_q.pop_front();
          chk("beat_cyc", 64'(cyc), 64'(b.cyc));
          chk("beat_addr", 64'(BRAM_ADDR), 64'(b.addr));
          chk("beat_we", 64'(BRAM_WE), 64'(b.we));
          chk("beat_din", 64'(BRAM_DIN), 64'(b.din));
          chk("beat_gnt", 64'({m1_gnt, m0_gnt}), (b.m == 0) ? 64'd1 : 64'd2);
        end
      end else if (m0_gnt || m1_gnt) begin
        fail("gnt_without_en");
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rv_q.size() == 0) fail("rvalid_extra");
        else begin
          e = rv_q.pop_front();
          chk("rv_cyc", 64'(cyc), 64'(e.cyc));
          chk("rv_route", 64'({m1_rvalid, m0_rvalid}), (e.m == 0) ? 64'd1 : 64'd2);
          chk("rdata0", 64'(m0_rdata), 64'(e.data));
          chk("rdata1", 64'(m1_rdata), 64'(e.data));
        end
      end
      if (m0_done || m1_done) begin
        if (done_q.size() == 0) fail("done_extra");
        else begin
          e = done_q.pop_front();
          chk("done_cyc", 64'(cyc), 64'(e.cyc));
          chk("done_who", 64'({m1_done, m0_done}), (e.m == 0) ? 64'd1 : 64'd2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 1'b0; m_len[m] = '0; m_addr[m] = '0; m_we[m] = '0; m_din[m] = '0;
    end
    rst = 1'b1;
    m_req[0] = 1'b1;
    step(); step();
    chk("rst_gnt0", 64'(m0_gnt), 64'd0);
    chk("rst_en", 64'(BRAM_EN), 64'd0);
    chk("rst_we", 64'(BRAM_WE), 64'd0);
    chk("rst_done", 64'({m1_done, m0_done}), 64'd0);
    chk("rst_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
    m_req[0] = 1'b0;
    rst = 1'b0;
    step(); step();

    // m0 write burst of 4 from idle
    c = cyc;
    for (int i = 0; i < 4; i++) pb(c + 1 + i, 0, i, 4'hF, 32'hA0 + i);
    pdone(c + 5, 0);
    master(0, 4, 0, 4'hF, 32'hA0, -1, 0);
    repeat (4) step();
    for (int i = 0; i < 4; i++) chk("mem_wr", 64'(mem[i]), 64'(32'hA0 + i));

    rst = 1'b1; step(); rst = 1'b0; step();

    // collision from reset: m0 first, m1 immediately after
    c = cyc;
    pb(c + 1, 0, 20, 4'hF, 32'hB0); pb(c + 2, 0, 21, 4'hF, 32'hB1);
    pb(c + 3, 1, 30, 4'hF, 32'hC0); pb(c + 4, 1, 31, 4'hF, 32'hC1);
    pdone(c + 3, 0); pdone(c + 5, 1);
    fork
      master(0, 2, 20, 4'hF, 32'hB0, -1, 0);
      master(1, 2, 30, 4'hF, 32'hC0, -1, 0);
    join
    repeat (4) step();

    c = cyc;
    pb(c + 1, 0, 22, 4'hF, 32'hB2);
    pdone(c + 2, 0);
    master(0, 1, 22, 4'hF, 32'hB2, -1, 0);
    repeat (4) step();

    // next collision: pointer now favours m1
    c = cyc;
    pb(c + 1, 1, 32, 4'hF, 32'hC2); pb(c + 2, 0, 23, 4'hF, 32'hB3);
    pdone(c + 2, 1); pdone(c + 3, 0);
    fork
      master(0, 1, 23, 4'hF, 32'hB3, -1, 0);
      master(1, 1, 32, 4'hF, 32'hC2, -1, 0);
    join
    repeat (4) step();

    // preload via back-to-back m0 single bursts, then m1 reads them
    c = cyc;
    pb(c + 1, 0, 10, 4'hF, 32'h11); pb(c + 2, 0, 11, 4'hF, 32'h22);
    pdone(c + 2, 0); pdone(c + 3, 0);
    master(0, 1, 10, 4'hF, 32'h11, -1, 0);
    master(0, 1, 11, 4'hF, 32'h22, -1, 0);
    repeat (4) step();

    c = cyc;
    pb(c + 1, 1, 10, 4'h0, 32'h0); pb(c + 2, 1, 11, 4'h0, 32'h0);
    prv(c + 2, 1, 32'h11); prv(c + 3, 1, 32'h22);
    pdone(c + 3, 1);
    master(1, 2, 10, 4'h0, 32'h0, -1, 0);
    repeat (4) step();

    // m0 stalls two cycles mid-burst while m1 waits
    c = cyc;
    pb(c + 1, 0, 40, 4'hF, 32'hD0); pb(c + 2, 0, 41, 4'hF, 32'hD1);
    pb(c + 5, 0, 42, 4'hF, 32'hD2); pb(c + 6, 0, 43, 4'hF, 32'hD3);
    pb(c + 7, 1, 50, 4'hF, 32'hE0);
    pdone(c + 7, 0); pdone(c + 8, 1);
    fork
      master(0, 4, 40, 4'hF, 32'hD0, 2, 2);
      master(1, 1, 50, 4'hF, 32'hE0, -1, 0);
    join
    repeat (4) step();

    // asynchronous reset during the second beat aborts without done
    c = cyc;
    pb(c + 1, 0, 60, 4'hF, 32'hF0);
    m_req[0] = 1'b1; m_len[0] = 8'd3; m_addr[0] = 60; m_we[0] = 4'hF; m_din[0] = 32'hF0;
    step();
    step();
    m_addr[0] = 61; m_din[0] = 32'hF1;
    #1 rst = 1'b1;
    #1;
    chk("arst_en", 64'(BRAM_EN), 64'd0);
    chk("arst_we", 64'(BRAM_WE), 64'd0);
    chk("arst_addr", 64'(BRAM_ADDR), 64'd0);
    chk("arst_gnt0", 64'(m0_gnt), 64'd0);
    chk("arst_done", 64'(m0_done), 64'd0);
    m_req[0] = 1'b0; m_we[0] = '0; m_din[0] = '0;
    #1 rst = 1'b0;
    repeat (3) step();

    c = cyc;
    for (int i = 0; i < 4; i++) pb(c + 1 + i, 0, 60 + i, 4'hF, 32'hF0 + i);
    pdone(c + 5, 0);
    master(0, 4, 60, 4'hF, 32'hF0, -1, 0);
    repeat (4) step();

    // alternating single beats, m1 first (pointer favours it)
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      pb(c + 1 + 2 * k, 1, 34 + k, 4'hF, 32'h70 + k);
      pb(c + 2 + 2 * k, 0, 24 + k, 4'hF, 32'h80 + k);
    end
    for (int k = 0; k < 3; k++) begin
      pdone(c + 2 + 2 * k, 1);
      pdone(c + 3 + 2 * k, 0);
    end
    fork
      begin
        for (int k = 0; k < 3; k++) master(1, 1, 34 + k, 4'hF, 32'h70 + k, -1, 0);
      end
      begin
        for (int k = 0; k < 3; k++) master(0, 1, 24 + k, 4'hF, 32'h80 + k, -1, 0);
      end
    join
    repeat (4) step();

    chk("beats_left", 64'(beat_q.size()), 64'd0);
    chk("rv_left", 64'(rv_q.size()), 64'd0);
    chk("done_left", 64'(done_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arb.md
BRAM_PORT_ARB -- requirements
Module: bram_port_arb

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, BRAM address width; DATA_W, default 32, data width; LEN_W, default 8, burst-length field width.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have the following ports, clock and reset first (direction, width, meaning):
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  requester 0 wants/holds the port (cnn core).
- m0_len  in  LEN_W  burst beats minus 1.
- m0_addr  in  ADDR_W  beat address.
- m0_we  in  4  byte write enables; 0 = read.
- m0_din  in  DATA_W  write data.
- m0_gnt  out  1  beat accepted this cycle.
- m0_rvalid  out  1  read data valid.
- m0_rdata  out  DATA_W  read data.
- m0_done  out  1  burst-complete pulse.
- m1_*  same set as m0_*, for requester 1 (host loader).
- BRAM_ADDR  out  ADDR_W  shared BRAM address.
- BRAM_WE  out  4  BRAM byte write enables.
- BRAM_EN  out  1  BRAM enable.
- BRAM_DIN  out  DATA_W  data to BRAM.
- BRAM_DOUT  in  DATA_W  data from BRAM, 1-cycle read latency.

Function
REQ-004 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-005 IDLE: on any mN_req high, SHALL pick the owner by round-robin pointer, latch that requester's len, and enter OWNn next edge (1 arbitration cycle, no beat issued).
REQ-006 Round-robin: after reset m0 has priority; after each completed burst, priority goes to the other requester.
REQ-007 OWNn: mN_gnt = mN_req (combinational); the other requester's gnt SHALL be 0.
REQ-008 Beat = OWNn & mN_req; on a beat SHALL drive BRAM_EN=1, BRAM_ADDR/WE/DIN = owner's signals.
REQ-009 With no beat, SHALL drive BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0.
REQ-010 Throughput SHALL be one beat per cycle while the owner holds req.
REQ-011 Owner dropping req mid-burst SHALL stall: beat counter holds, ownership retained, no preemption.
REQ-012 Burst SHALL end on beat number latched len+1; len=0 means a single beat.
REQ-013 At burst end: if the other requester is requesting, SHALL go directly to its OWN state (latching its len); else if the same requester is requesting, OWN same state; else IDLE. Zero idle cycles on handoff.
REQ-014 mN_done SHALL be a registered one-cycle pulse, the cycle after the last beat.
REQ-015 Read beat (EN & WE==0) SHALL produce mN_rvalid one cycle later, routed to the issuing requester via a registered tag.
REQ-016 m0_rdata and m1_rdata SHALL both equal BRAM_DOUT (broadcast); valid only with rvalid.
REQ-017 Write beats SHALL produce no rvalid.
REQ-018 len inputs SHALL be ignored except at latch time.

Reset
REQ-019 rst SHALL, asynchronously:
- set state to IDLE, pointer to m0, beat counter to 0, latched len to 0, rvalid/done/tag to 0;
- force all gnt and BRAM_EN/WE to 0.
REQ-020 Reset mid-burst SHALL abort the burst with no done pulse; a later request SHALL restart arbitration from IDLE.

Structure
REQ-021 A shared package SHALL hold the state encoding and default ADDR_W/DATA_W/LEN_W constants.
REQ-022 The round-robin pick SHALL be a sub-module bram_rr_pick2 (2 requests + pointer -> one-hot pick), purely combinational.

Verification
REQ-023 Bench SHALL cover:
- m0 write len=3 at addr 0..3, data A0..A3 -> 1 idle cycle then 4 consecutive BRAM_EN; mem[0..3]=A0..A3; m0_done one pulse.
- m0 and m1 req same cycle from IDLE -> m0 owns first, m1 starts the cycle after m0's last beat; next collision -> m1 wins.
- m1 read len=1, addr 10/11 preloaded 0x11/0x22 -> m1_rvalid on 2 cycles, rdata 0x11 then 0x22; m0_rvalid stays 0.
- m0 drops req 2 cycles mid-burst with m1 requesting -> BRAM_EN low 2 cycles; m1_gnt stays 0 until m0 done.
- rst pulsed between edges during beat 2 -> outputs 0 immediately, no done; re-request performs full 4 beats.
- m0 and m1 alternating len=0 -> one beat each per cycle, done after each, no idle between.
